// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: main entry plus one-deep skid entry, so the
// upstream ready is a pure flop. Flush kills held entries and the current input.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_pc/in_ins    upstream entry offer
//   in_ready                 registered accept indication (no skid entry held)
//   out_valid/out_pc/out_ins main entry; pc=0 and ins=NOP_INS when invalid
//   out_ready                downstream accept
//   flush                    synchronous kill of held entries and current input
//   cnt_clr                  synchronous clear of both counters
//   stall_cnt/flush_cnt      saturating performance counters
module pipe_stage_reg #(
    parameter int              PC_W    = 32,
    parameter int              INS_W   = 32,
    parameter logic [INS_W-1:0] NOP_INS = 32'h0000_0013,
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             m_valid_q, m_valid_d;
    logic [PC_W-1:0]  m_pc_q,    m_pc_d;
    logic [INS_W-1:0] m_ins_q,   m_ins_d;
    logic             s_valid_q, s_valid_d;
    logic [PC_W-1:0]  s_pc_q,    s_pc_d;
    logic [INS_W-1:0] s_ins_q,   s_ins_d;
    logic [CNT_W-1:0] stall_q,   stall_d;
    logic [CNT_W-1:0] flush_q,   flush_d;

    logic accept;
    logic drain;
    logic m_free;
    logic stall;

    assign in_ready = ~s_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = m_valid_q & out_ready;
    assign m_free   = ~m_valid_q | drain;
    assign stall    = m_valid_q & ~out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_ins_d   = m_ins_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_ins_d   = s_ins_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            // Skid entry is older than any new input, so it moves up first.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_ins_d   = s_ins_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_pc_d    = in_pc;
                m_ins_d   = in_ins;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_pc_d    = in_pc;
            s_ins_d   = in_ins;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall && stall_q != {CNT_W{1'b1}}) begin
                stall_d = stall_q + 1'b1;
            end
            if (flush && flush_q != {CNT_W{1'b1}}) begin
                flush_d = flush_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_pc_q    <= '0;
            m_ins_q   <= NOP_INS;
            s_valid_q <= 1'b0;
            s_pc_q    <= '0;
            s_ins_q   <= NOP_INS;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_pc_q    <= m_pc_d;
            m_ins_q   <= m_ins_d;
            s_valid_q <= s_valid_d;
            s_pc_q    <= s_pc_d;
            s_ins_q   <= s_ins_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_pc    = m_valid_q ? m_pc_q : '0;
    assign out_ins   = m_valid_q ? m_ins_q : NOP_INS;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted inputs are queued at the clock
// edge, a negedge monitor pops and compares on every downstream handshake.
module tb_pipe_stage_reg;

    localparam int PC_W  = 32;
    localparam int INS_W = 32;
    localparam int CNT_W = 4;
    localparam logic [INS_W-1:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [PC_W-1:0]  in_pc;
    logic [INS_W-1:0] in_ins;
    logic             in_ready;
    logic             out_valid;
    logic [PC_W-1:0]  out_pc;
    logic [INS_W-1:0] out_ins;
    logic             out_ready;
    logic             flush;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    logic [PC_W+INS_W-1:0] exp_q[$];

    pipe_stage_reg #(
        .PC_W(PC_W), .INS_W(INS_W), .NOP_INS(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_ins(out_ins),
        .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] ins_of(input logic [PC_W-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected-response producer: an input is taken exactly when the stage
    // accepts it on this edge; a flush kills everything still held.
    always @(posedge clk) begin
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back({in_pc, in_ins});
            end
        end
    end

    // Monitor: compare on handshake, and check hold of the head while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {out_pc, out_ins}, 64'hDEAD);
            end else if (out_ready) begin
                chk("out_data", {out_pc, out_ins}, exp_q.pop_front());
            end else begin
                chk("hold_data", {out_pc, out_ins}, exp_q[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [PC_W-1:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_ins   = ins_of(pc);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        offer(1'b0, '0);
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ins", out_ins, NOP);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        step();
        step();
        rst = 1'b0;

        // Streaming
        out_ready = 1'b1;
        offer(1'b1, 32'h4);
        step();
        chk("s_pc4", out_pc, 32'h4);
        chk("s_rdy4", in_ready, 1);
        offer(1'b1, 32'h8);
        step();
        chk("s_pc8", out_pc, 32'h8);
        chk("s_rdy8", in_ready, 1);
        offer(1'b1, 32'hC);
        step();
        chk("s_pcC", out_pc, 32'hC);
        chk("s_rdyC", in_ready, 1);
        offer(1'b0, '0);
        step();
        chk("s_empty", out_valid, 0);
        chk("s_stall", stall_cnt, 0);

        // Stall and skid
        out_ready = 1'b0;
        offer(1'b1, 32'h10);
        step();
        offer(1'b1, 32'h14);
        step();
        chk("k_rdy_low", in_ready, 0);
        chk("k_pc10a", out_pc, 32'h10);
        offer(1'b1, 32'h18);
        step();
        chk("k_pc10b", out_pc, 32'h10);
        chk("k_rdy_low2", in_ready, 0);
        chk("k_stall2", stall_cnt, 2);
        out_ready = 1'b1;
        step();
        chk("k_pc14", out_pc, 32'h14);
        chk("k_rdy_back", in_ready, 1);
        step();
        chk("k_pc18", out_pc, 32'h18);
        offer(1'b0, '0);
        step();
        chk("k_empty", out_valid, 0);
        chk("k_stall_end", stall_cnt, 2);

        // Flush with full buffer
        out_ready = 1'b0;
        offer(1'b1, 32'h20);
        step();
        offer(1'b1, 32'h24);
        step();
        chk("f_full", in_ready, 0);
        flush = 1'b1;
        offer(1'b1, 32'h28);
        step();
        flush = 1'b0;
        offer(1'b0, '0);
        chk("f_valid", out_valid, 0);
        chk("f_ins", out_ins, NOP);
        chk("f_pc", out_pc, 0);
        chk("f_rdy", in_ready, 1);
        chk("f_cnt", flush_cnt, 1);
        step();
        chk("f_valid2", out_valid, 0);

        // Flush coincident with drain
        out_ready = 1'b1;
        offer(1'b1, 32'h30);
        step();
        chk("d_pc30", out_pc, 32'h30);
        offer(1'b0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("d_empty", out_valid, 0);
        chk("d_cnt", flush_cnt, 2);
        step();
        chk("d_empty2", out_valid, 0);

        // Counter saturation and clear
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("c_clr_s", stall_cnt, 0);
        chk("c_clr_f", flush_cnt, 0);
        out_ready = 1'b0;
        offer(1'b1, 32'h40);
        step();
        offer(1'b0, '0);
        for (int i = 0; i < 20; i++) step();
        chk("c_sat", stall_cnt, 15);
        step();
        chk("c_sat_hold", stall_cnt, 15);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("c_clr_win", stall_cnt, 0);
        step();
        chk("c_resume", stall_cnt, 1);

        // Async reset mid-stall
        offer(1'b1, 32'h44);
        step();
        offer(1'b0, '0);
        chk("r_full", in_ready, 0);
        chk("r_valid_pre", out_valid, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("r_valid", out_valid, 0);
        chk("r_rdy", in_ready, 1);
        chk("r_pc", out_pc, 0);
        chk("r_stall", stall_cnt, 0);
        step();
        rst = 1'b0;
        chk("r_after", out_valid, 0);

        out_ready = 1'b1;
        offer(1'b1, 32'h50);
        step();
        chk("p_pc50", out_pc, 32'h50);
        offer(1'b0, '0);
        step();
        step();
        chk("q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
